axis_variable_sink: RTL and testbench
=====================================

# axis_variable_sink

AXI4-Stream slave that terminates a stream into a register-style output word, the receive-side counterpart of the variable-to-stream source. Each accepted beat, or each block-average of 2^AVG_LOG2 beats, updates `data_out` and pulses `data_updated` for one cycle; a wrapping counter reports how many updates have occurred. It sits at the end of a stream chain (ADC/DSP path) and feeds status/config registers or slow control logic.

## Interface
- `AXIS_TDATA_WIDTH`, 32, stream and output word width; data is two's-complement signed.
- `AVG_LOG2`, 0, log2 of block-average length; legal range 0..8; 0 means pass-through latch.
- `COUNT_WIDTH`, 32, width of `sample_count`.

- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  stream data.
- `s_axis_tvalid`  in  1  stream valid.
- `s_axis_tready`  out  1  stream ready.
- `hold`  in  1  back-pressure request; 1 stops acceptance.
- `clear`  in  1  synchronous discard of partial block and `sample_count`.
- `data_out`  out  AXIS_TDATA_WIDTH  last latched/averaged value.
- `data_updated`  out  1  one-cycle pulse coincident with a new `data_out`.
- `sample_count`  out  COUNT_WIDTH  number of `data_out` updates since reset/clear.

## Operation
- `s_axis_tready` is registered: next value = ~hold. One cycle of latency from `hold` to `tready`.
- A beat is accepted on an edge where `s_axis_tvalid & s_axis_tready`. No other condition consumes data.
- Accumulator: width AXIS_TDATA_WIDTH+AVG_LOG2, signed. Beat counter: AVG_LOG2 bits (absent when 0).
- On an accepted beat with beat counter < 2^AVG_LOG2-1: acc += sign-extended tdata; counter++.
- On an accepted beat with counter = 2^AVG_LOG2-1:
  - `data_out` <= (acc + sext(tdata)) >>> AVG_LOG2, an arithmetic shift that truncates toward −∞.
  - acc <= 0, counter <= 0, `data_updated` <= 1, `sample_count` += 1.
- AVG_LOG2=0: every accepted beat updates `data_out` directly.
- `data_updated` <= 0 on every edge without a block completion.
- `sample_count` wraps from 2^COUNT_WIDTH-1 to 0 without saturation.
- `clear`=1:
  - acc, counter and `sample_count` <= 0. `data_out` is retained and no pulse is produced.
  - A beat accepted in the same cycle is consumed and discarded; `clear` has priority.
- `hold` only throttles `tready`. A beat accepted on the edge where `tready` is still 1 is processed normally.

## Timing
- Reset values: `s_axis_tready`=0, `data_out`=0, `data_updated`=0, `sample_count`=0; acc and counter =0.
- `tready` first rises one cycle after `aresetn` goes high, when `hold`=0.
- Latency: the edge that accepts the completing beat updates `data_out`, `data_updated` and `sample_count` together. All three are visible in the following cycle.
- Back-to-back completions (AVG_LOG2=0, continuous valid) hold `data_updated` high continuously and increment `sample_count` every cycle. Throughput is 1 beat/cycle.
- Reset mid-block drops the partial accumulation with no update.
- Averaging arithmetic cannot overflow: the accumulator holds 2^AVG_LOG2 full-scale samples exactly.

## Structure
- Shared package `axis_variable_pkg`:
  - `AVG_LOG2_MAX`=8 constant.
  - `acc_width(w, l)` function returning w+l.
  - Sign-extension helper.
- Elaboration check that AVG_LOG2 ≤ AVG_LOG2_MAX.
- One sub-module `axis_block_avg`: accumulator, beat counter and shift, with `in_valid`/`in_data`/`clear` in and `out_valid`/`out_data` out. The top keeps the `tready` register, `data_out`, and `sample_count`.

## Test plan
- Reset, AVG_LOG2=0: hold `aresetn` low 3 cycles with `tvalid`=1. `tready`=0 throughout and all outputs 0. `tready`=1 one cycle after release.
- AVG_LOG2=0, stream 5, 7, −1 back-to-back: `data_out`=5, 7, 0xFFFFFFFF on successive cycles. `data_updated` is high 3 cycles, then `sample_count`=3.
- AVG_LOG2=2, beats 1, 2, 3, 4: a single update `data_out`=2 (10>>>2). Beats −1, −1, −1, −2: `data_out`=−2 (−5>>>2). `data_updated` pulses exactly on the 4th and 8th acceptances.
- `hold` raised for 4 cycles during continuous valid: `tready` falls 1 cycle later and rises 1 cycle after `hold` drops. No beat is lost or duplicated (verify by an incrementing pattern).
- AVG_LOG2=2, 2 beats then `clear` together with a 3rd beat: no update. The next 4 beats 8, 8, 8, 8 give `data_out`=8 and `sample_count`=1. `data_out` is unchanged during the clear.
- COUNT_WIDTH=4, AVG_LOG2=0, 17 beats: `sample_count` reaches 15, wraps to 0, then reads 1.

Source files
------------

// File: rtl/axis_variable_pkg.sv
// Shared constants and helpers for the variable stream source/sink blocks.
package axis_variable_pkg;

    localparam int unsigned AVG_LOG2_MAX   = 8;
    localparam int unsigned DATA_WIDTH_MAX = 64;
    localparam int unsigned SEXT_WIDTH     = DATA_WIDTH_MAX + AVG_LOG2_MAX;

    function automatic int unsigned acc_width(input int unsigned w, input int unsigned l);
        return w + l;
    endfunction

    // Sign-extends the low w bits of d across the full helper width.
    function automatic logic [SEXT_WIDTH-1:0] sext(input logic [SEXT_WIDTH-1:0] d,
                                                   input int unsigned          w);
        logic signed [SEXT_WIDTH-1:0] t;
        t = $signed(d << (SEXT_WIDTH - w));
        return t >>> (SEXT_WIDTH - w);
    endfunction

endpackage

// File: rtl/axis_block_avg.sv
// Block averager: sums 2^AVG_LOG2 accepted samples and emits the floor-shifted mean.
module axis_block_avg
    import axis_variable_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AVG_LOG2   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  clear_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    localparam int unsigned AW = acc_width(DATA_WIDTH, AVG_LOG2);

    logic signed [AW-1:0] sample;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 last;

    assign sample = $signed(AW'(sext(SEXT_WIDTH'(in_data_i), DATA_WIDTH)));
    assign sum    = acc_q + sample;

    if (AVG_LOG2 == 0) begin : g_pass
        assign last = 1'b1;
    end else begin : g_cnt
        logic [AVG_LOG2-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (in_valid_i) begin
                cnt_d = cnt_q + AVG_LOG2'(1);
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign last = &cnt_q;
    end

    always_comb begin
        acc_d = acc_q;
        if (clear_i || (in_valid_i && last)) begin
            acc_d = '0;
        end else if (in_valid_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // A beat arriving with clear is swallowed, so it never completes a block.
    assign out_valid_o = in_valid_i & last & ~clear_i;
    assign out_data_o  = DATA_WIDTH'(sum >>> AVG_LOG2);

endmodule

// File: rtl/axis_variable_sink.sv
// AXI4-Stream sink that latches each beat (or block average) into a register word.
module axis_variable_sink
    import axis_variable_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 32,
    parameter int unsigned AVG_LOG2         = 0,
    parameter int unsigned COUNT_WIDTH      = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        hold,
    input  logic                        clear,
    output logic [AXIS_TDATA_WIDTH-1:0] data_out,
    output logic                        data_updated,
    output logic [COUNT_WIDTH-1:0]      sample_count
);

    if (AVG_LOG2 > AVG_LOG2_MAX) begin : g_avg_log2_check
        $error("axis_variable_sink: AVG_LOG2 exceeds AVG_LOG2_MAX");
    end

    if (AXIS_TDATA_WIDTH > DATA_WIDTH_MAX) begin : g_width_check
        $error("axis_variable_sink: AXIS_TDATA_WIDTH exceeds DATA_WIDTH_MAX");
    end

    logic                        tready_q, tready_d;
    logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
    logic                        upd_q, upd_d;
    logic [COUNT_WIDTH-1:0]      count_q, count_d;

    logic                        accept;
    logic                        blk_valid;
    logic [AXIS_TDATA_WIDTH-1:0] blk_data;

    assign accept = s_axis_tvalid & tready_q;

    axis_block_avg #(
        .DATA_WIDTH (AXIS_TDATA_WIDTH),
        .AVG_LOG2   (AVG_LOG2)
    ) u_block_avg (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .in_valid_i  (accept),
        .in_data_i   (s_axis_tdata),
        .clear_i     (clear),
        .out_valid_o (blk_valid),
        .out_data_o  (blk_data)
    );

    always_comb begin
        tready_d = ~hold;
        data_d   = data_q;
        upd_d    = blk_valid;
        count_d  = count_q;
        if (clear) begin
            count_d = '0;
        end else if (blk_valid) begin
            data_d  = blk_data;
            count_d = count_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tready_q <= 1'b0;
            data_q   <= '0;
            upd_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            tready_q <= tready_d;
            data_q   <= data_d;
            upd_q    <= upd_d;
            count_q  <= count_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign data_out      = data_q;
    assign data_updated  = upd_q;
    assign sample_count  = count_q;

endmodule

// File: tb/tb_axis_variable_sink.sv
// Drives a pass-through and a 4-beat averaging sink with one stream, checked against a reference model.
module tb_axis_variable_sink;

    localparam int unsigned W = 32;

    logic         aclk    = 1'b0;
    logic         aresetn = 1'b0;
    logic [W-1:0] tdata   = '0;
    logic         tvalid  = 1'b0;
    logic         hold    = 1'b0;
    logic         clear   = 1'b0;

    logic         tready0, tready1, upd0, upd1;
    logic [W-1:0] dout0, dout1;
    logic [3:0]   cnt0;
    logic [31:0]  cnt1;

    always #5 aclk = ~aclk;

    axis_variable_sink #(
        .AXIS_TDATA_WIDTH (W),
        .AVG_LOG2         (0),
        .COUNT_WIDTH      (4)
    ) u_dut0 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready0),
        .hold          (hold),
        .clear         (clear),
        .data_out      (dout0),
        .data_updated  (upd0),
        .sample_count  (cnt0)
    );

    axis_variable_sink #(
        .AXIS_TDATA_WIDTH (W),
        .AVG_LOG2         (2),
        .COUNT_WIDTH      (32)
    ) u_dut1 (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready1),
        .hold          (hold),
        .clear         (clear),
        .data_out      (dout1),
        .data_updated  (upd1),
        .sample_count  (cnt1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic [31:0] c;
    } upd_t;

    upd_t sb0[$];
    upd_t sb1[$];

    // Reference model: per configuration, a running block sum and beat count.
    int unsigned lg[2]      = '{0, 2};
    longint      cmask[2]   = '{64'd15, 64'hFFFF_FFFF};
    longint      blk_sum[2] = '{0, 0};
    longint      blk_n[2]   = '{0, 0};
    longint      m_cnt[2]   = '{0, 0};
    logic [31:0] m_out[2]   = '{32'd0, 32'd0};
    bit          m_upd[2]   = '{1'b0, 1'b0};
    bit          m_tready   = 1'b0;

    function automatic longint floordiv(input longint num, input longint den);
        longint q;
        q = num / den;
        if ((num % den) != 0 && num < 0) q = q - 1;
        return q;
    endfunction

    always @(posedge aclk) begin
        bit     acc;
        longint q;
        upd_t   e;
        acc = tvalid && m_tready;
        if (!aresetn) begin
            m_tready = 1'b0;
            for (int k = 0; k < 2; k++) begin
                blk_sum[k] = 0;
                blk_n[k]   = 0;
                m_cnt[k]   = 0;
                m_out[k]   = '0;
                m_upd[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_upd[k] = 1'b0;
                if (clear) begin
                    blk_sum[k] = 0;
                    blk_n[k]   = 0;
                    m_cnt[k]   = 0;
                end else if (acc) begin
                    blk_sum[k] = blk_sum[k] + longint'($signed(tdata));
                    blk_n[k]   = blk_n[k] + 1;
                    if (blk_n[k] == (longint'(1) << lg[k])) begin
                        q          = floordiv(blk_sum[k], blk_n[k]);
                        m_out[k]   = q[31:0];
                        m_cnt[k]   = (m_cnt[k] + 1) & cmask[k];
                        m_upd[k]   = 1'b1;
                        blk_sum[k] = 0;
                        blk_n[k]   = 0;
                        e.d = m_out[k];
                        e.c = 32'(m_cnt[k]);
                        if (k == 0) sb0.push_back(e);
                        else        sb1.push_back(e);
                    end
                end
            end
            m_tready = !hold;
        end
    end

    always @(negedge aclk) begin
        upd_t e;
        chk("tready0", 64'(tready0), 64'(m_tready));
        chk("tready1", 64'(tready1), 64'(m_tready));
        if (upd0 === 1'b1) begin
            if (sb0.size() == 0) begin
                chk("sb0_unexpected_update", 64'(upd0), 64'd0);
            end else begin
                e = sb0.pop_front();
                chk("sb0_data", 64'(dout0), 64'(e.d));
                chk("sb0_count", 64'(cnt0), 64'(e.c));
            end
        end
        if (upd1 === 1'b1) begin
            if (sb1.size() == 0) begin
                chk("sb1_unexpected_update", 64'(upd1), 64'd0);
            end else begin
                e = sb1.pop_front();
                chk("sb1_data", 64'(dout1), 64'(e.d));
                chk("sb1_count", 64'(cnt1), 64'(e.c));
            end
        end
        chk("upd0", 64'(upd0), 64'(m_upd[0]));
        chk("upd1", 64'(upd1), 64'(m_upd[1]));
        chk("cnt0", 64'(cnt0), m_cnt[0]);
        chk("cnt1", 64'(cnt1), m_cnt[1]);
        chk("dout0", 64'(dout0), 64'(m_out[0]));
        chk("dout1", 64'(dout1), 64'(m_out[1]));
    end

    task automatic cyc(input logic v, input logic [31:0] d, input logic h, input logic c);
        tvalid = v;
        tdata  = d;
        hold   = h;
        clear  = c;
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'($signed($urandom_range(0, 15)) - 8);
            default: return $urandom;
        endcase
    endfunction

    task automatic random_phase(input int n);
        logic        pv;
        logic [31:0] pd;
        pv = 1'b0;
        pd = '0;
        for (int i = 0; i < n; i++) begin
            logic a;
            if (!pv) begin
                pv = ($urandom_range(0, 3) != 0);
                pd = rand_data();
            end
            a = pv && tready0;
            cyc(pv, pd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
            if (a) pv = 1'b0;
        end
    endtask

    int          dir_vals[8] = '{1, 2, 3, 4, -1, -1, -1, -2};
    logic [31:0] inc;

    initial begin
        aresetn = 1'b0;
        tvalid  = 1'b1;
        tdata   = $urandom;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        cyc(1'b1, 32'd5, 1'b0, 1'b0);
        cyc(1'b1, 32'd7, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);

        foreach (dir_vals[i]) cyc(1'b1, 32'(dir_vals[i]), 1'b0, 1'b0);

        cyc(1'b1, 32'd3, 1'b0, 1'b0);
        cyc(1'b1, 32'd3, 1'b0, 1'b0);
        cyc(1'b1, 32'd3, 1'b0, 1'b1);
        repeat (4) cyc(1'b1, 32'd8, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        inc = 32'd100;
        for (int i = 0; i < 20; i++) begin
            logic h;
            logic a;
            h = (i >= 5 && i < 9);
            a = tready0;
            cyc(1'b1, inc, h, 1'b0);
            if (a) inc = inc + 1;
        end

        cyc(1'b0, '0, 1'b0, 1'b1);
        repeat (17) cyc(1'b1, $urandom, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        random_phase(3000);

        cyc(1'b1, 32'd11, 1'b0, 1'b0);
        cyc(1'b1, 32'd13, 1'b0, 1'b0);
        tvalid  = 1'b0;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        random_phase(800);
        repeat (5) cyc(1'b0, '0, 1'b0, 1'b0);

        chk("sb0_drained", 64'(sb0.size()), 64'd0);
        chk("sb1_drained", 64'(sb1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
